// File: rtl/debounce_pkg.sv
// Shared defaults and width helper for the multi-channel button debouncer.
// Optional long-press detection is enabled with the DEBOUNCE_LONG_PRESS_EN macro.
package debounce_pkg;

   localparam int unsigned DefThreshold  = 4;
   localparam int unsigned DefLongCycles = 1000000;

   // Width needed to hold values 0..max_val; never below one bit.
   function automatic int unsigned cnt_width(input int unsigned max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/debounce_ch.sv
// Single debounce channel: 2-flop synchroniser, stability filter and edge pulses.
// With DEBOUNCE_LONG_PRESS_EN defined, a saturating hold counter drives long_o.
module debounce_ch
   import debounce_pkg::*;
#(
   parameter int unsigned THRESHOLD   = DefThreshold,
   parameter int unsigned CNT_W       = cnt_width(THRESHOLD),
   parameter int unsigned LONG_CYCLES = DefLongCycles
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o,
   output logic long_o
);

   localparam logic [CNT_W-1:0] CntLast = CNT_W'(THRESHOLD - 1);

   logic             sync1_q, sync2_q;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             level_q, level_d;
   logic             rise_q, rise_d;
   logic             fall_q, fall_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= btn_i;
         sync2_q <= sync1_q;
      end
   end

   // Any matching cycle clears the count; the THRESHOLD-th mismatch commits the change.
   always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntLast) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            fall_d  = ~sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int unsigned       HOLD_W  = cnt_width(LONG_CYCLES);
   localparam logic [HOLD_W-1:0] HoldMax = HOLD_W'(LONG_CYCLES);

   logic [HOLD_W-1:0] hold_q, hold_d;
   logic              long_q, long_d;

   // Saturates at HoldMax so a single press yields at most one pulse.
   always_comb begin
      hold_d = hold_q;
      long_d = 1'b0;
      if (!level_q) begin
         hold_d = '0;
      end else if (hold_q != HoldMax) begin
         hold_d = hold_q + HOLD_W'(1);
         long_d = (hold_q == HoldMax - HOLD_W'(1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hold_q <= '0;
         long_q <= 1'b0;
      end else begin
         hold_q <= hold_d;
         long_q <= long_d;
      end
   end

   assign long_o = long_q;
`else
   assign long_o = 1'b0;
`endif

endmodule

// File: rtl/debounce_multi.sv
// N independent debounce channels for board push-buttons and switches.
// Long-press pulses on long_o exist only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_multi
   import debounce_pkg::*;
#(
   parameter int unsigned NUM_CH      = 4,
   parameter int unsigned THRESHOLD   = DefThreshold,
   parameter int unsigned CNT_W       = cnt_width(THRESHOLD),
   parameter int unsigned LONG_CYCLES = DefLongCycles
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NUM_CH-1:0] btn_i,
   output logic [NUM_CH-1:0] level_o,
   output logic [NUM_CH-1:0] rise_o,
   output logic [NUM_CH-1:0] fall_o,
   output logic [NUM_CH-1:0] long_o
);

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      debounce_ch #(
         .THRESHOLD  (THRESHOLD),
         .CNT_W      (CNT_W),
         .LONG_CYCLES(LONG_CYCLES)
      ) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .btn_i  (btn_i[i]),
         .level_o(level_o[i]),
         .rise_o (rise_o[i]),
         .fall_o (fall_o[i]),
         .long_o (long_o[i])
      );
   end

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: directed scenarios plus random button activity, all
// compared against a window-based reference model of the debounce rules.
module tb_debounce_multi;

   localparam int unsigned NUM_CH = 4;
   localparam int unsigned THR    = 4;
   localparam int unsigned LONG   = 20;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NUM_CH-1:0] btn = '0;
   logic [NUM_CH-1:0] level_o, rise_o, fall_o, long_o;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   debounce_multi #(
      .NUM_CH     (NUM_CH),
      .THRESHOLD  (THR),
      .LONG_CYCLES(LONG)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .btn_i  (btn),
      .level_o(level_o),
      .rise_o (rise_o),
      .fall_o (fall_o),
      .long_o (long_o)
   );

   // Reference model: sync delay line plus a window of the last THR synchronised
   // samples; level flips when every sample in the window disagrees with it.
   bit                d1 [NUM_CH];
   bit                d2 [NUM_CH];
   bit                win[NUM_CH][$];
   bit                m_level[NUM_CH];
   int                held[NUM_CH];
   logic [NUM_CH-1:0] m_lvl, m_rise, m_fall, m_long;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         d1[i] = 0;
         d2[i] = 0;
         win[i].delete();
         m_level[i] = 0;
         held[i] = 0;
      end
      m_lvl = '0; m_rise = '0; m_fall = '0; m_long = '0;
   endtask

   task automatic model_step(input logic [NUM_CH-1:0] b);
      for (int i = 0; i < NUM_CH; i++) begin
         bit s, prev, all_diff;
         s = d2[i];
         d2[i] = d1[i];
         d1[i] = b[i];
         win[i].push_back(s);
         if (win[i].size() > THR) void'(win[i].pop_front());
         prev = m_level[i];
         all_diff = (win[i].size() == THR);
         foreach (win[i][k]) if (win[i][k] == prev) all_diff = 0;
         m_rise[i] = 1'b0;
         m_fall[i] = 1'b0;
         if (all_diff) begin
            m_level[i] = !prev;
            m_rise[i] = !prev;
            m_fall[i] = prev;
         end
         m_lvl[i] = m_level[i];
         held[i] = prev ? held[i] + 1 : 0;
`ifdef DEBOUNCE_LONG_PRESS_EN
         m_long[i] = prev && (held[i] == LONG);
`else
         m_long[i] = 1'b0;
`endif
      end
   endtask

   // Drive one cycle of input, advance DUT and model, then compare away from the edge.
   task automatic step(input logic [NUM_CH-1:0] b);
      btn = b;
      @(posedge clk);
      model_step(b);
      #1;
      check("level", 32'(level_o), 32'(m_lvl));
      check("rise", 32'(rise_o), 32'(m_rise));
      check("fall", 32'(fall_o), 32'(m_fall));
      check("long", 32'(long_o), 32'(m_long));
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_level"}, 32'(level_o), 32'd0);
      check({tag, "_rise"}, 32'(rise_o), 32'd0);
      check({tag, "_fall"}, 32'(fall_o), 32'd0);
      check({tag, "_long"}, 32'(long_o), 32'd0);
   endtask

   initial begin
      int lat, nrise, nfall, nlong, idx, rise_at, long_at;
      logic [NUM_CH-1:0] seen;
      logic [NUM_CH-1:0] bounce [9];
      logic [NUM_CH-1:0] r;

      // Reset held with all buttons pressed.
      model_reset();
      btn = '1;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset_hold");
      @(negedge clk);
      rst_n = 1'b1;

      // Clean step on channel 0.
      repeat (6) step(4'b0000);
      lat = 0; nrise = 0; nfall = 0;
      for (int k = 1; k <= 12; k++) begin
         step(4'b0001);
         if (level_o[0] && lat == 0) lat = k;
         if (rise_o[0]) nrise++;
         if (fall_o != 0) nfall++;
      end
      check("step_latency", 32'(lat), 32'd6);
      check("step_rise_count", 32'(nrise), 32'd1);
      check("step_no_fall", 32'(nfall), 32'd0);
      repeat (10) step(4'b0000);

      // Three-cycle glitch on channel 1 must be ignored.
      seen = '0;
      repeat (3) begin step(4'b0010); seen |= level_o | rise_o | fall_o; end
      repeat (10) begin step(4'b0000); seen |= level_o | rise_o | fall_o; end
      check("glitch_ch1", 32'(seen[1]), 32'd0);

      // Simultaneous rise on channels 1 and 3, then fall on channel 3 only.
      seen = '0;
      repeat (10) begin step(4'b1010); if (rise_o != 0 && seen == 0) seen = rise_o; end
      check("simul_rise", 32'(seen), 32'b1010);
      seen = '0;
      repeat (10) begin step(4'b0010); if (fall_o != 0 && seen == 0) seen = fall_o; end
      check("indep_fall", 32'(seen), 32'b1000);
      check("indep_ch1_high", 32'(level_o[1]), 32'd1);
      repeat (10) step(4'b0000);

      // Bounce on channel 2, then settle high.
      bounce = '{4'b0100, 4'b0000, 4'b0100, 4'b0100, 4'b0000,
                 4'b0100, 4'b0100, 4'b0100, 4'b0100};
      nrise = 0; rise_at = -1;
      for (int j = 0; j < 17; j++) begin
         step(j < 9 ? bounce[j] : 4'b0100);
         if (rise_o[2]) begin nrise++; rise_at = j; end
      end
      check("bounce_rise_count", 32'(nrise), 32'd1);
      check("bounce_rise_at", 32'(rise_at), 32'd10);
      repeat (10) step(4'b0000);

`ifdef DEBOUNCE_LONG_PRESS_EN
      // Long press on channel 3, twice.
      for (int p = 0; p < 2; p++) begin
         nlong = 0; rise_at = -1; long_at = -1;
         for (int k = 0; k < 40; k++) begin
            step(4'b1000);
            if (rise_o[3]) rise_at = k;
            if (long_o[3]) begin nlong++; long_at = k; end
         end
         check("long_count", 32'(nlong), 32'd1);
         check("long_delay", 32'(long_at - rise_at), 32'(LONG));
         repeat (10) step(4'b0000);
      end
`endif

      // Asynchronous reset mid-cycle with levels high and counts in flight.
      repeat (10) step(4'b1111);
      repeat (2) step(4'b0101);
      #2;
      rst_n = 1'b0;
      #1;
      check_zero("async_reset");
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      lat = 0;
      for (int k = 1; k <= 10; k++) begin
         step(4'b1111);
         if (rise_o == 4'b1111 && lat == 0) lat = k;
      end
      check("rearm_latency", 32'(lat), 32'd6);

      // Random activity: sparse toggles so both glitches and clean changes occur.
      r = 4'b1111;
      for (int k = 0; k < 1500; k++) begin
         for (int i = 0; i < NUM_CH; i++) if ($urandom_range(5) == 0) r[i] = ~r[i];
         step(r);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Synchronises N asynchronous push-button/switch inputs into `clk` and filters each one independently with a programmable stability threshold.
- Outputs per channel: a clean level, a one-cycle rising-edge pulse and a one-cycle falling-edge pulse.
- Sits between the board button pins and game-control logic (flap, start, reset-game). Consumers use the edge pulses directly and need no edge detection of their own.

Parameters:
- NUM_CH, 4: number of independent input channels (>=1).
- THRESHOLD, 4: consecutive synchronised mismatch cycles required before a level change is accepted (>=1).
- CNT_W, $clog2(THRESHOLD+1): per-channel counter width. Derived; not for override.
- LONG_CYCLES, 1000000: hold duration for the long-press pulse. Used only with the optional feature.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- btn_i  input  NUM_CH  raw asynchronous button inputs, bit i = channel i.
- level_o  output  NUM_CH  debounced level.
- rise_o  output  NUM_CH  one-cycle pulse on each accepted 0->1 change.
- fall_o  output  NUM_CH  one-cycle pulse on each accepted 1->0 change.
- long_o  output  NUM_CH  one-cycle long-press pulse (optional feature; otherwise constant 0).

Behaviour:
- Reset (rst_n low, asynchronous assert):
  - sync flops, counters, level_o, rise_o, fall_o and long_o all go to 0 immediately.
  - Release is sampled on the clk rising edge.
- Synchroniser: 2-flop chain per channel. sync[i] is btn_i[i] delayed 2 cycles.
- Per-channel filter, evaluated every clk edge:
  - sync[i] == level_o[i]: count <= 0.
  - sync[i] != level_o[i] and count == THRESHOLD-1: level_o[i] <= sync[i]; count <= 0; the matching edge pulse asserts.
  - sync[i] != level_o[i] otherwise: count <= count+1.
- Acceptance: a change is accepted on the edge that completes the THRESHOLD-th consecutive mismatch cycle.
- Any single matching cycle clears the count. A glitch of width < THRESHOLD cycles at sync never changes level_o.
- Latency: a clean step on btn_i appears on level_o exactly 2+THRESHOLD edges later.
- rise_o/fall_o:
  - Registered; high for exactly the first cycle in which level_o shows the new value.
  - Never high simultaneously on one channel.
  - Minimum spacing between pulses on a channel is THRESHOLD cycles.
- Channels are fully independent. Simultaneous changes on several channels produce simultaneous pulses.
- Counter never exceeds THRESHOLD-1; no wrap-around possible.
- THRESHOLD=1: a change is accepted on the first mismatch cycle.
- Reset mid-count: count is discarded. After release, an input held high is re-accepted with full latency and produces a rise_o pulse.

Optional Feature:
- Macro: DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - Each channel has a hold counter of width $clog2(LONG_CYCLES+1), cleared while level_o[i]==0 and incremented while level_o[i]==1.
  - When the counter reaches LONG_CYCLES, long_o[i] pulses for one cycle.
  - The counter then saturates, so there is no repeat until level_o[i] falls and rises again.
  - Reset clears the counter.
- Undefined: long_o is tied to 0 and no hold counters are instantiated.

Decomposition:
- Shared package debounce_pkg: the default THRESHOLD, default LONG_CYCLES, and a helper function for the counter width.
- One natural sub-module, debounce_ch: synchroniser + filter + edge pulses (+ hold counter under the macro) for a single channel.
- debounce_multi instantiates NUM_CH copies of debounce_ch in a generate loop.

Test Plan (all with NUM_CH=4, THRESHOLD=4):
- Reset: hold rst_n=0 with btn_i=4'hF; assert rst_n low asynchronously mid-cycle -> all outputs 0 with no clock edge required.
- Clean step: btn_i[0] 0->1 after release -> level_o[0]=1 exactly 6 edges later; rise_o[0]=4'b0001 for one cycle; no fall_o.
- Glitch rejection: btn_i[1] high for 3 cycles, then low -> level_o, rise_o and fall_o stay 0 on channel 1.
- Simultaneous and independent channels: btn_i 4'b0000->4'b1010, then 10 cycles later 4'b1010->4'b0010 -> rise_o=4'b1010 in one cycle; later fall_o=4'b1000 only; channel 1 stays high.
- Bounce then settle: btn_i[2] toggles 1,0,1,1,0,1,1,1,1 per cycle -> exactly one rise_o[2] pulse, 2+4 edges after the final stable run begins.
- Long press (DEBOUNCE_LONG_PRESS_EN, LONG_CYCLES=20): hold btn_i[3] high for 40 cycles -> exactly one long_o[3] pulse, 20 cycles after level_o[3] rises; release and re-press -> second pulse.
